// File: rtl/adc_ov_uv_monitor.sv
// ---------------------------------------------------------------------------
// adc_ov_uv_monitor
//
// Drives a serial ADC (cs_n / adclk / ad_in), assembles each NBITS-wide
// conversion result MSB first, and debounces over- and under-voltage flags
// against fixed thresholds with hysteresis on the clear side.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   enable continuous sampling
//   ad_in      in   ADC serial data (MSB first)
//   adclk      out  ADC serial clock (only toggles while cs_n is low)
//   cs_n       out  ADC chip select, active low
//   sample     out  last completed conversion
//   sample_vld out  one-cycle pulse when sample updates
//   ov         out  debounced over-voltage flag
//   uv         out  debounced under-voltage flag
// ---------------------------------------------------------------------------
module adc_ov_uv_monitor #(
  parameter int CLK_DIV  = 4,
  parameter int NBITS    = 8,
  parameter int CONV_CYC = 20,
  parameter int OV_TH    = 200,
  parameter int UV_TH    = 50,
  parameter int HYST     = 4,
  parameter int CONFIRM  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ad_in,
  output logic             adclk,
  output logic             cs_n,
  output logic [NBITS-1:0] sample,
  output logic             sample_vld,
  output logic             ov,
  output logic             uv
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CONV  = 3'd4
  } state_t;

  localparam int MAX_CYC = (CLK_DIV > CONV_CYC) ? CLK_DIV : CONV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int TH_W    = NBITS + 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);
  localparam logic [3:0]       CONF_LAST = 4'(CONFIRM - 1);

  // Thresholds carry one extra bit so the hysteresis offsets never wrap;
  // the OV clear level is clamped at zero instead of underflowing.
  localparam logic [TH_W-1:0] OV_SET_TH = TH_W'(OV_TH);
  localparam logic [TH_W-1:0] OV_CLR_TH = TH_W'((OV_TH > HYST) ? (OV_TH - HYST) : 0);
  localparam logic [TH_W-1:0] UV_SET_TH = TH_W'(UV_TH);
  localparam logic [TH_W-1:0] UV_CLR_TH = TH_W'(UV_TH + HYST);

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   div_cnt_r, div_cnt_nxt_s;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic [NBITS-1:0]   shift_r;
  logic               shift_en_s;
  logic               capture_s;
  logic               cs_n_r, adclk_r, sample_vld_r;
  logic [NBITS-1:0]   sample_r;
  logic               ov_r, uv_r;
  logic [3:0]         ov_set_cnt_r, ov_clr_cnt_r, uv_set_cnt_r, uv_clr_cnt_r;
  logic [TH_W-1:0]    sample_ext_s;
  logic               ov_hit_s, ov_clr_hit_s, uv_hit_s, uv_clr_hit_s;

  assign cs_n       = cs_n_r;
  assign adclk      = adclk_r;
  assign sample     = sample_r;
  assign sample_vld = sample_vld_r;
  assign ov         = ov_r;
  assign uv         = uv_r;

  assign sample_ext_s = {1'b0, sample_r};
  assign ov_hit_s     = (sample_ext_s > OV_SET_TH);
  assign ov_clr_hit_s = (sample_ext_s < OV_CLR_TH);
  assign uv_hit_s     = (sample_ext_s < UV_SET_TH);
  assign uv_clr_hit_s = (sample_ext_s > UV_CLR_TH);

  // Frame sequencer: next state, phase counter, bit counter and strobes.
  always_comb begin
    state_nxt_s   = state_r;
    div_cnt_nxt_s = div_cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_en_s    = 1'b0;
    capture_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        div_cnt_nxt_s = {CNT_W{1'b0}};
        bit_cnt_nxt_s = {BIT_W{1'b0}};
        if (en) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_cnt_r == DIV_LAST) begin
          state_nxt_s   = ST_HI;
          div_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          div_cnt_nxt_s = div_cnt_r + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (div_cnt_r == DIV_LAST) begin
          // Sample ad_in on the edge that drops adclk.
          shift_en_s    = 1'b1;
          state_nxt_s   = ST_LO;
          div_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          div_cnt_nxt_s = div_cnt_r + CNT_W'(1);
        end
      end
      ST_LO: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_nxt_s = {CNT_W{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s   = ST_CONV;
            bit_cnt_nxt_s = {BIT_W{1'b0}};
            capture_s     = 1'b1;
          end else begin
            state_nxt_s   = ST_HI;
            bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + CNT_W'(1);
        end
      end
      ST_CONV: begin
        if (div_cnt_r == CONV_LAST) begin
          div_cnt_nxt_s = {CNT_W{1'b0}};
          if (en) begin
            state_nxt_s = ST_SETUP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        div_cnt_nxt_s = {CNT_W{1'b0}};
        bit_cnt_nxt_s = {BIT_W{1'b0}};
      end
    endcase
  end

  // Sequencer registers plus registered ADC pins and captured sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      div_cnt_r    <= {CNT_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      shift_r      <= {NBITS{1'b0}};
      cs_n_r       <= 1'b1;
      adclk_r      <= 1'b0;
      sample_r     <= {NBITS{1'b0}};
      sample_vld_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      if (shift_en_s) begin
        shift_r <= {shift_r[NBITS-2:0], ad_in};
      end
      // Pins are decoded from the next state so they change on the same
      // edge as the state itself.
      cs_n_r       <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_CONV);
      adclk_r      <= (state_nxt_s == ST_HI);
      sample_vld_r <= capture_s;
      if (capture_s) begin
        sample_r <= shift_r;
      end
    end
  end

  // Over-voltage debounce, evaluated once per new sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_r         <= 1'b0;
      ov_set_cnt_r <= 4'd0;
      ov_clr_cnt_r <= 4'd0;
    end else if (sample_vld_r) begin
      if (!ov_r) begin
        ov_clr_cnt_r <= 4'd0;
        if (!ov_hit_s) begin
          ov_set_cnt_r <= 4'd0;
        end else if (ov_set_cnt_r == CONF_LAST) begin
          ov_r         <= 1'b1;
          ov_set_cnt_r <= 4'd0;
        end else begin
          ov_set_cnt_r <= ov_set_cnt_r + 4'd1;
        end
      end else begin
        ov_set_cnt_r <= 4'd0;
        if (!ov_clr_hit_s) begin
          ov_clr_cnt_r <= 4'd0;
        end else if (ov_clr_cnt_r == CONF_LAST) begin
          ov_r         <= 1'b0;
          ov_clr_cnt_r <= 4'd0;
        end else begin
          ov_clr_cnt_r <= ov_clr_cnt_r + 4'd1;
        end
      end
    end
  end

  // Under-voltage debounce, same scheme with the comparisons mirrored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uv_r         <= 1'b0;
      uv_set_cnt_r <= 4'd0;
      uv_clr_cnt_r <= 4'd0;
    end else if (sample_vld_r) begin
      if (!uv_r) begin
        uv_clr_cnt_r <= 4'd0;
        if (!uv_hit_s) begin
          uv_set_cnt_r <= 4'd0;
        end else if (uv_set_cnt_r == CONF_LAST) begin
          uv_r         <= 1'b1;
          uv_set_cnt_r <= 4'd0;
        end else begin
          uv_set_cnt_r <= uv_set_cnt_r + 4'd1;
        end
      end else begin
        uv_set_cnt_r <= 4'd0;
        if (!uv_clr_hit_s) begin
          uv_clr_cnt_r <= 4'd0;
        end else if (uv_clr_cnt_r == CONF_LAST) begin
          uv_r         <= 1'b0;
          uv_clr_cnt_r <= 4'd0;
        end else begin
          uv_clr_cnt_r <= uv_clr_cnt_r + 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/adc_ov_uv_monitor.md
Name: adc_ov_uv_monitor

Overview:
- Upstream sense stage for the protection controller: drives a serial 8-bit ADC (chip-select, serial clock, serial data out), assembles each conversion result, and qualifies it against over- and under-voltage thresholds.
- Produces the debounced `ov` / `uv` fault levels and the raw sample consumed by the protection/relay/LED unit.

Parameters:
- CLK_DIV, 4: clk cycles per adclk half-period; also the length of the cs_n-low setup time; range ≥ 1.
- NBITS, 8: ADC result width, shifted MSB first.
- CONV_CYC, 20: clk cycles cs_n is held high between frames (ADC conversion time); range ≥ 1.
- OV_TH, 200: over-voltage set threshold; sample > OV_TH counts as an over-voltage hit.
- UV_TH, 50: under-voltage set threshold; sample < UV_TH counts as an under-voltage hit.
- HYST, 4: hysteresis, in codes, applied to clear conditions.
- CONFIRM, 3: consecutive qualifying samples needed to set or clear a flag; range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  enable continuous sampling
- ad_in  in  1  ADC serial data out
- adclk  out  1  ADC serial clock
- cs_n  out  1  ADC chip select, active low
- sample  out  NBITS  last completed conversion
- sample_vld  out  1  one-cycle pulse when sample updates
- ov  out  1  debounced over-voltage flag
- uv  out  1  debounced under-voltage flag

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values: cs_n=1, adclk=0, sample=0, sample_vld=0, ov=0, uv=0. State=IDLE; all counters and the shift register = 0.
- Reset mid-frame aborts the frame immediately; the partial sample is discarded.
- States:
  - IDLE: cs_n=1, adclk=0. Go to SETUP on the first edge with en=1.
  - SETUP: cs_n=0 for CLK_DIV cycles, then go to HI.
  - HI: adclk=1 for CLK_DIV cycles. On the final cycle's edge, shift ad_in into the shift register LSB (MSB arrives first), then go to LO.
  - LO: adclk=0 for CLK_DIV cycles. If this is bit NBITS-1, go to CONV; else go to HI.
  - CONV: on entry edge, cs_n=1, sample ← shift register, and sample_vld=1 for exactly one cycle. Hold CONV_CYC cycles. Then go to SETUP if en=1, else IDLE.
- Frame length: CLK_DIV + 2·NBITS·CLK_DIV + CONV_CYC. With defaults this is 88 cycles from cs_n falling to the next cs_n falling.
- en=0 mid-frame: the current frame completes, including its sample_vld; no new frame starts.
- adclk never toggles while cs_n=1.
- ov qualification (evaluated on each sample_vld, using the new sample):
  - While ov=0: a hit is sample > OV_TH.
  - While ov=1: a clear-hit is sample < OV_TH−HYST.
  - Separate saturating counters count consecutive hits and clear-hits; a non-qualifying sample resets its counter to 0.
  - ov toggles on the same edge the counter reaches CONFIRM, i.e. one cycle after the sample_vld pulse; that counter then resets.
- uv qualification: identical scheme. A hit is sample < UV_TH; a clear-hit is sample > UV_TH+HYST.
- Boundaries:
  - sample == OV_TH or == UV_TH is not a hit.
  - Samples inside the hysteresis band hold the flag and reset the clear counter.
  - ov and uv are independent.
  - Threshold arithmetic uses NBITS+1 bits, so UV_TH+HYST cannot wrap and OV_TH−HYST cannot underflow below 0.

Test Plan:
- Reset/idle: rst_n=0 for 5 cycles with en=0, then release → cs_n=1, adclk=0, all outputs 0, no adclk edges for 200 cycles.
- Frame timing and capture: en=1, ADC model shifts out 0xA5 → cs_n low 4 cycles before the first adclk rise; exactly 8 adclk pulses of 4 high / 4 low; sample=0xA5 with a one-cycle sample_vld at the cs_n rise; next cs_n fall 88 cycles after the previous one.
- OV set/boundary: samples 200,210,210,210 → no set on 200; ov=1 one cycle after the third 210's sample_vld. Then 210,210,100,210 from a cleared state → ov stays 0.
- OV hysteresis clear: with ov=1, samples 197,197,197 → ov stays 1; then 195,195,195 → ov=0 after the third.
- UV set/clear: samples 48×3 → uv=1; then 54,55,55,55 → uv=0 only after the third 55; ov stays 0 throughout.
- Disable/reset mid-frame: drop en during bit 3 → frame completes, sample_vld fires, then IDLE. Then assert rst_n=0 during bit 5 of a new frame → next edge cs_n=1, adclk=0, ov=uv=0, sample=0.
